// File: rtl/ser8_pkg.sv
// Shared definitions for the 8-bit serial transmitter: word width, default
// patterns, state encoding and a saturating counter helper.
package ser8_pkg;

  localparam int WORD_W = 8;

  localparam logic [WORD_W-1:0] DEF_TRAIN_PAT = 8'h5C;
  localparam logic [WORD_W-1:0] DEF_IDLE_PAT  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } ser8_state_e;

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ser8_shift.sv
// LSB-first shift register with a free-running bit counter; a new word loads
// on the edge where the counter reads 7 (the word boundary).
module ser8_shift
  import ser8_pkg::*;
(
  input  logic              i_pclk,
  input  logic              i_resetn,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_dout,
  output logic              o_sof,
  output logic              o_boundary
);

  logic [WORD_W-1:0] r_sreg;
  logic [2:0]        r_bitCnt;
  logic              r_sof;

  // Counter resets to 7 so the first edge after reset is already a boundary.
  assign o_boundary = (r_bitCnt == 3'd7);

  always_ff @(posedge i_pclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sreg   <= '0;
      r_bitCnt <= 3'd7;
      r_sof    <= 1'b0;
    end else begin
      r_bitCnt <= r_bitCnt + 3'd1;
      r_sof    <= o_boundary;
      if (o_boundary) begin
        r_sreg <= i_word;
      end else begin
        r_sreg <= {1'b0, r_sreg[WORD_W-1:1]};
      end
    end
  end

  assign o_dout = r_sreg[0];
  assign o_sof  = r_sof;

endmodule

// File: rtl/ser8_tx.sv
// 8-bit serial transmitter: one-entry hold register, IDLE/TRAIN/DATA word
// selection at word boundaries. Optional status counters with SER8_TX_STATUS_EN.
module ser8_tx
  import ser8_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PAT   = DEF_TRAIN_PAT,
  parameter logic [WORD_W-1:0] IDLE_PAT    = DEF_IDLE_PAT,
  parameter int                TRAIN_WORDS = 16
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              train,
  output logic              dout,
  output logic              dout_sof,
  output logic [1:0]        state
`ifdef SER8_TX_STATUS_EN
  ,
  output logic [15:0]       word_cnt,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam logic [7:0] TRAIN_WORDS_C = 8'(TRAIN_WORDS);

  ser8_state_e       r_state;
  ser8_state_e       w_stateNxt;
  logic [WORD_W-1:0] r_hold;
  logic              r_holdValid;
  logic              r_trainReq;
  logic [7:0]        r_trainCnt;
  logic [WORD_W-1:0] w_loadWord;
  logic              w_boundary;
  logic              w_accept;

  // Gated by resetn so the block never advertises ready while held in reset.
  assign din_ready = !r_holdValid && resetn;
  assign w_accept  = din_valid && !r_holdValid;
  assign state     = r_state;

  ser8_shift u_shift (
    .i_pclk     (pclk),
    .i_resetn   (resetn),
    .i_word     (w_loadWord),
    .o_dout     (dout),
    .o_sof      (dout_sof),
    .o_boundary (w_boundary)
  );

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  // A latched train request means a one-cycle pulse mid-word still starts
  // training at the next boundary; the current word is never disturbed.
  always_comb begin
    w_stateNxt = r_state;
    w_loadWord = IDLE_PAT;
    if (w_boundary) begin
      if (train || r_trainReq) begin
        w_stateNxt = ST_TRAIN;
      end else if (r_state == ST_TRAIN && r_trainCnt < TRAIN_WORDS_C) begin
        w_stateNxt = ST_TRAIN;
      end else if (r_holdValid) begin
        w_stateNxt = ST_DATA;
      end else begin
        w_stateNxt = ST_IDLE;
      end
    end
    case (w_stateNxt)
      ST_TRAIN: w_loadWord = TRAIN_PAT;
      ST_DATA:  w_loadWord = r_hold;
      default:  w_loadWord = IDLE_PAT;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_hold      <= '0;
      r_holdValid <= 1'b0;
    end else if (w_boundary && w_stateNxt == ST_DATA) begin
      r_holdValid <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= din;
      r_holdValid <= 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_trainReq <= 1'b0;
      r_trainCnt <= 8'd0;
    end else begin
      if (w_boundary) begin
        r_trainReq <= 1'b0;
      end else if (train) begin
        r_trainReq <= 1'b1;
      end
      if (w_boundary) begin
        if (w_stateNxt != ST_TRAIN) begin
          r_trainCnt <= 8'd0;
        end else if (r_state != ST_TRAIN) begin
          r_trainCnt <= 8'd1;
        end else if (r_trainCnt != 8'hFF) begin
          r_trainCnt <= r_trainCnt + 8'd1;
        end
      end
    end
  end

`ifdef SER8_TX_STATUS_EN
  logic [15:0] r_wordCnt;
  logic [15:0] r_underrunCnt;

  // An underrun is an idle word loaded straight after a data word.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_wordCnt     <= 16'd0;
      r_underrunCnt <= 16'd0;
    end else if (w_boundary) begin
      if (w_stateNxt == ST_DATA) begin
        r_wordCnt <= satInc16(r_wordCnt);
      end
      if (w_stateNxt == ST_IDLE && r_state == ST_DATA) begin
        r_underrunCnt <= satInc16(r_underrunCnt);
      end
    end
  end

  assign word_cnt     = r_wordCnt;
  assign underrun_cnt = r_underrunCnt;
`endif

endmodule

// File: tb/tb_ser8_tx.sv
// Scoreboard bench for ser8_tx: stimulus queues expected words, a monitor
// reassembles serial words at each dout_sof and compares them.
module tb_ser8_tx;

  localparam logic [7:0] IDLE_W  = 8'h00;
  localparam logic [7:0] TRAIN_W = 8'h5C;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRAIN = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  typedef struct packed {
    logic [7:0] w;
    logic [1:0] s;
  } expWord_t;

  logic       pclk;
  logic       resetn;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       train;
  logic       dout;
  logic       dout_sof;
  logic [1:0] state;
`ifdef SER8_TX_STATUS_EN
  logic [15:0] word_cnt;
  logic [15:0] underrun_cnt;
`endif

  int checksRun    = 0;
  int checksPassed = 0;

  expWord_t expQ[$];

  ser8_tx dut (
    .pclk         (pclk),
    .resetn       (resetn),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .train        (train),
    .dout         (dout),
    .dout_sof     (dout_sof),
    .state        (state)
`ifdef SER8_TX_STATUS_EN
    ,
    .word_cnt     (word_cnt),
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checksRun++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic [7:0] w, input logic [1:0] s);
    expWord_t e;
    e.w = w;
    e.s = s;
    expQ.push_back(e);
  endtask

  // Present a word and return one negedge after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] w);
    bit accepted;
    accepted  = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (din_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 16'd0, 16'd1);
    end
    @(negedge pclk);
  endtask

  task automatic waitSof();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (dout_sof) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput("sof_timeout", 16'd0, 16'd1);
    end
  endtask

  task automatic drainQueue(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (expQ.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    if (!done) begin
      checkOutput("drain_timeout", 16'(expQ.size()), 16'd0);
    end
  endtask

  // Monitor: rebuild each word from dout starting at dout_sof; with nothing
  // queued the link is expected to be idling.
  int         capIdx;
  int         sinceSof;
  bit         capturing;
  bit         sofSeen;
  logic [7:0] capWord;
  logic [1:0] capState;

  always @(negedge pclk or negedge resetn) begin
    expWord_t e;
    if (!resetn) begin
      capturing = 1'b0;
      capIdx    = 0;
      sofSeen   = 1'b0;
      sinceSof  = 0;
    end else begin
      sinceSof++;
      if (dout_sof) begin
        if (sofSeen) begin
          checkOutput("sof_period", 16'(sinceSof), 16'd8);
        end
        sofSeen    = 1'b1;
        sinceSof   = 0;
        capturing  = 1'b1;
        capIdx     = 0;
        capWord    = 8'h00;
        capWord[0] = dout;
        capState   = state;
      end else if (capturing) begin
        capIdx++;
        capWord[capIdx] = dout;
        if (capIdx == 7) begin
          capturing = 1'b0;
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
          end else begin
            e.w = IDLE_W;
            e.s = S_IDLE;
          end
          checkOutput("word", {8'h00, capWord}, {8'h00, e.w});
          checkOutput("word_state", {14'h0, capState}, {14'h0, e.s});
        end
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    train     = 1'b0;

    #2;
    checkOutput("rst_dout", {15'h0, dout}, 16'd0);
    checkOutput("rst_sof", {15'h0, dout_sof}, 16'd0);
    checkOutput("rst_din_ready", {15'h0, din_ready}, 16'd0);
    checkOutput("rst_state", {14'h0, state}, {14'h0, S_IDLE});

    repeat (2) @(posedge pclk);
    #1;
    resetn = 1'b1;
    #1;
    checkOutput("release_din_ready", {15'h0, din_ready}, 16'd1);

    // Idle after reset: first edge is a boundary, sof at cycles 1 and 9.
    @(posedge pclk);
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      checkOutput("idle_dout", {15'h0, dout}, 16'd0);
      checkOutput("idle_sof", {15'h0, dout_sof}, (i == 0 || i == 8) ? 16'd1 : 16'd0);
      checkOutput("idle_state", {14'h0, state}, {14'h0, S_IDLE});
      checkOutput("idle_din_ready", {15'h0, din_ready}, 16'd1);
    end

    // Single word A5.
    waitSof();
    pushExp(IDLE_W, S_IDLE);
    pushExp(8'hA5, S_DATA);
    applyStimulus(8'hA5);
    din_valid = 1'b0;
    checkOutput("hold_full_ready", {15'h0, din_ready}, 16'd0);
    drainQueue(40);

    // Back-to-back words with no idle gaps.
    waitSof();
    pushExp(IDLE_W, S_IDLE);
    pushExp(8'h01, S_DATA);
    pushExp(8'h80, S_DATA);
    pushExp(8'hFF, S_DATA);
    applyStimulus(8'h01);
    applyStimulus(8'h80);
    applyStimulus(8'hFF);
    din_valid = 1'b0;
    drainQueue(60);

    // One-cycle train pulse mid-word with a word pending in hold.
    waitSof();
    pushExp(IDLE_W, S_IDLE);
    pushExp(8'h11, S_DATA);
    for (int i = 0; i < 16; i++) begin
      pushExp(TRAIN_W, S_TRAIN);
    end
    pushExp(8'h22, S_DATA);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    din_valid = 1'b0;
    @(negedge pclk);
    train = 1'b1;
    @(negedge pclk);
    train = 1'b0;
    drainQueue(400);

    // Reset at bit 4 of F0: output clears at once and F0 never reappears.
    waitSof();
    pushExp(IDLE_W, S_IDLE);
    pushExp(8'hF0, S_DATA);
    applyStimulus(8'hF0);
    din_valid = 1'b0;
    waitSof();
    repeat (4) @(negedge pclk);
    checkOutput("pre_reset_bit4", {15'h0, dout}, 16'd1);
    resetn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midrst_dout", {15'h0, dout}, 16'd0);
    checkOutput("midrst_sof", {15'h0, dout_sof}, 16'd0);
    checkOutput("midrst_din_ready", {15'h0, din_ready}, 16'd0);
    checkOutput("midrst_state", {14'h0, state}, {14'h0, S_IDLE});
    repeat (2) @(negedge pclk);
    resetn = 1'b1;
    #1;
    checkOutput("rerelease_din_ready", {15'h0, din_ready}, 16'd1);
    repeat (40) @(negedge pclk);

`ifdef SER8_TX_STATUS_EN
    // Three words, a gap, then one word: four data words, two underruns.
    checkOutput("word_cnt_reset", word_cnt, 16'd0);
    checkOutput("underrun_cnt_reset", underrun_cnt, 16'd0);
    waitSof();
    pushExp(IDLE_W, S_IDLE);
    pushExp(8'hAA, S_DATA);
    pushExp(8'hBB, S_DATA);
    pushExp(8'hCC, S_DATA);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    din_valid = 1'b0;
    drainQueue(60);
    repeat (16) @(negedge pclk);
    waitSof();
    pushExp(IDLE_W, S_IDLE);
    pushExp(8'hDD, S_DATA);
    applyStimulus(8'hDD);
    din_valid = 1'b0;
    drainQueue(40);
    repeat (10) @(negedge pclk);
    checkOutput("word_cnt", word_cnt, 16'd4);
    checkOutput("underrun_cnt", underrun_cnt, 16'd2);
`endif

    checkOutput("queue_empty", 16'(expQ.size()), 16'd0);
    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
